// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman host-side word loader.
package hangman_pkg;

    typedef enum logic [1:0] {
        ENTRY,
        ARMED,
        LOCKED
    } loader_state_t;

    localparam int unsigned WORD_LEN = 5;
    localparam int unsigned CHAR_W   = 8;
    localparam logic [7:0]  ASCII_A  = 8'h41;
    localparam logic [7:0]  ASCII_Z  = 8'h5A;
    localparam logic [7:0]  CASE_BIT = 8'h20;

endpackage

// File: rtl/char_validator.sv
// Combinational keypad character check; accepts 'A'..'Z'.
// With HOST_CASE_FOLD_EN defined, 'a'..'z' is also accepted and folded to uppercase.
module char_validator
    import hangman_pkg::*;
(
    input  logic [CHAR_W-1:0] ch,
    output logic              is_valid,
    output logic [CHAR_W-1:0] norm_char
);

    always_comb begin
        is_valid  = (ch >= ASCII_A) && (ch <= ASCII_Z);
        norm_char = ch;
`ifdef HOST_CASE_FOLD_EN
        if ((ch >= (ASCII_A | CASE_BIT)) && (ch <= (ASCII_Z | CASE_BIT))) begin
            is_valid  = 1'b1;
            norm_char = ch & ~CASE_BIT;
        end
`endif
    end

endmodule

// File: rtl/host_word_loader.sv
// Collects the host's secret word letter by letter, then hands it to the game logic
// with a one-cycle start pulse and holds it locked. Optional feature: HOST_CASE_FOLD_EN.
module host_word_loader #(
    parameter int unsigned WORD_LEN = hangman_pkg::WORD_LEN,
    parameter int unsigned CHAR_W   = hangman_pkg::CHAR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_valid,
    input  logic [CHAR_W-1:0]          key_data,
    input  logic                       key_del,
    input  logic                       key_enter,
    input  logic                       new_game,
    input  logic                       game_rdy,
    output logic [WORD_LEN*CHAR_W-1:0] setWord,
    output logic                       toggle_state,
    output logic [2:0]                 letter_cnt,
    output logic                       load_err,
    output logic                       locked
);

    import hangman_pkg::*;

    localparam int unsigned W    = WORD_LEN * CHAR_W;
    localparam logic [2:0]  FULL = 3'(WORD_LEN);

    loader_state_t     state;
    logic              char_ok;
    logic [CHAR_W-1:0] char_norm;

    char_validator u_char_validator (
        .ch        (key_data),
        .is_valid  (char_ok),
        .norm_char (char_norm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ENTRY;
            setWord      <= '0;
            letter_cnt   <= '0;
            toggle_state <= 1'b0;
            load_err     <= 1'b0;
            locked       <= 1'b0;
        end else begin
            toggle_state <= 1'b0;
            load_err     <= 1'b0;
            if (new_game) begin
                state      <= ENTRY;
                setWord    <= '0;
                letter_cnt <= '0;
                locked     <= 1'b0;
            end else begin
                case (state)
                    // Strobe priority: delete, then letter, then enter; losers are dropped.
                    ENTRY: begin
                        if (key_del) begin
                            if (letter_cnt != 3'd0) begin
                                setWord    <= {{CHAR_W{1'b0}}, setWord[W-1:CHAR_W]};
                                letter_cnt <= letter_cnt - 3'd1;
                            end else begin
                                load_err <= 1'b1;
                            end
                        end else if (key_valid) begin
                            if (char_ok && (letter_cnt < FULL)) begin
                                setWord    <= {setWord[W-CHAR_W-1:0], char_norm};
                                letter_cnt <= letter_cnt + 3'd1;
                            end else begin
                                load_err <= 1'b1;
                            end
                        end else if (key_enter) begin
                            if (letter_cnt == FULL) begin
                                state <= ARMED;
                            end else begin
                                load_err <= 1'b1;
                            end
                        end
                    end
                    // A delete after confirm reopens editing with the last letter removed.
                    ARMED: begin
                        if (key_del) begin
                            setWord    <= {{CHAR_W{1'b0}}, setWord[W-1:CHAR_W]};
                            letter_cnt <= FULL - 3'd1;
                            state      <= ENTRY;
                        end else if (game_rdy) begin
                            toggle_state <= 1'b1;
                            locked       <= 1'b1;
                            state        <= LOCKED;
                        end
                    end
                    LOCKED: begin
                    end
                    default: state <= ENTRY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_host_word_loader.sv
// Self-checking bench for host_word_loader: queue-based reference model plus directed cases.
module tb_host_word_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [7:0]  key_data = 8'h00;
    logic        key_del = 1'b0;
    logic        key_enter = 1'b0;
    logic        new_game = 1'b0;
    logic        game_rdy = 1'b0;
    logic [39:0] setWord;
    logic        toggle_state;
    logic [2:0]  letter_cnt;
    logic        load_err;
    logic        locked;

    int n_checks = 0;
    int n_pass   = 0;
    bit run_cmp  = 1'b0;

    host_word_loader dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .key_del      (key_del),
        .key_enter    (key_enter),
        .new_game     (new_game),
        .game_rdy     (game_rdy),
        .setWord      (setWord),
        .toggle_state (toggle_state),
        .letter_cnt   (letter_cnt),
        .load_err     (load_err),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    // Reference model: letters held as a queue, mode 0=entering, 1=confirmed, 2=in game.
    logic [7:0] mq[$];
    int         mmode;
    bit         m_tog;
    bit         m_err;

    function automatic bit accept(input logic [7:0] c, output logic [7:0] n);
        n = c;
        if (c >= 8'd65 && c <= 8'd90) return 1'b1;
`ifdef HOST_CASE_FOLD_EN
        if (c >= 8'd97 && c <= 8'd122) begin
            n = c - 8'd32;
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    function automatic logic [39:0] m_word();
        logic [39:0] w = '0;
        foreach (mq[i]) w = (w << 8) | 40'(mq[i]);
        return w;
    endfunction

    task automatic model_reset();
        mq.delete();
        mmode = 0;
        m_tog = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0] n;
        bit ok;
        if (rst) begin
            model_reset();
            return;
        end
        m_tog = 1'b0;
        m_err = 1'b0;
        ok = accept(key_data, n);
        if (new_game) begin
            mq.delete();
            mmode = 0;
        end else if (mmode == 0) begin
            if (key_del) begin
                if (mq.size() > 0) void'(mq.pop_back());
                else m_err = 1'b1;
            end else if (key_valid) begin
                if (ok && mq.size() < 5) mq.push_back(n);
                else m_err = 1'b1;
            end else if (key_enter) begin
                if (mq.size() == 5) mmode = 1;
                else m_err = 1'b1;
            end
        end else if (mmode == 1) begin
            if (key_del) begin
                void'(mq.pop_back());
                mmode = 0;
            end else if (game_rdy) begin
                m_tog = 1'b1;
                mmode = 2;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            chk("cmp_word", 64'(setWord), 64'(m_word()));
            chk("cmp_cnt", 64'(letter_cnt), 64'(mq.size()));
            chk("cmp_toggle", 64'(toggle_state), 64'(m_tog));
            chk("cmp_err", 64'(load_err), 64'(m_err));
            chk("cmp_locked", 64'(locked), 64'(mmode == 2));
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic key(input logic [7:0] c);
        key_valid = 1'b1;
        key_data  = c;
        step();
        key_valid = 1'b0;
    endtask

    task automatic del();
        key_del = 1'b1;
        step();
        key_del = 1'b0;
    endtask

    task automatic enter();
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
    endtask

    task automatic ng();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    task automatic type_word(input logic [39:0] w);
        logic [39:0] t = w;
        for (int i = 0; i < 5; i++) begin
            key(t[39:32]);
            t = t << 8;
        end
    endtask

    initial begin
        int tog;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        run_cmp = 1'b1;
        chk("reset_word", 64'(setWord), 64'h0);
        chk("reset_cnt", 64'(letter_cnt), 64'h0);
        chk("reset_locked", 64'(locked), 64'h0);
        chk("reset_toggle", 64'(toggle_state), 64'h0);

        // HELLO, confirm with game ready
        type_word(40'h48454C4C4F);
        game_rdy = 1'b1;
        enter();
        tog = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (toggle_state) tog++;
        end
        game_rdy = 1'b0;
        chk("hello_word", 64'(setWord), 64'h48454C4C4F);
        chk("hello_pulses", 64'(tog), 64'd1);
        chk("hello_locked", 64'(locked), 64'h1);
        key(8'h41);
        chk("locked_ignores_key", 64'(setWord), 64'h48454C4C4F);
        ng();

        // Short word confirm
        key(8'h41);
        key(8'h42);
        enter();
        chk("short_enter_err", 64'(load_err), 64'h1);
        chk("short_enter_cnt", 64'(letter_cnt), 64'd2);
        step();
        chk("short_enter_notog", 64'(toggle_state), 64'h0);

        // Delete behaviour
        key(8'h43);
        del();
        chk("del_word", 64'(setWord), 64'h0000004142);
        chk("del_cnt", 64'(letter_cnt), 64'd2);
        del();
        del();
        chk("del_empty_noerr", 64'(load_err), 64'h0);
        del();
        chk("del_at_zero_err", 64'(load_err), 64'h1);
        chk("del_at_zero_cnt", 64'(letter_cnt), 64'd0);

        // Invalid and lowercase characters
        key(8'h31);
        chk("digit_err", 64'(load_err), 64'h1);
        chk("digit_cnt", 64'(letter_cnt), 64'd0);
        key(8'h61);
`ifdef HOST_CASE_FOLD_EN
        chk("lower_fold_word", 64'(setWord), 64'h41);
        chk("lower_fold_noerr", 64'(load_err), 64'h0);
`else
        chk("lower_reject_err", 64'(load_err), 64'h1);
        chk("lower_reject_word", 64'(setWord), 64'h0);
`endif
        key(8'h5B);
        key(8'h40);
        ng();

        // Overfill, then wait for game ready
        type_word(40'h574F524453);
        key(8'h58);
        chk("overfill_err", 64'(load_err), 64'h1);
        chk("overfill_cnt", 64'(letter_cnt), 64'd5);
        enter();
        tog = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (toggle_state) tog++;
        end
        chk("wait_no_toggle", 64'(tog), 64'd0);
        chk("wait_unlocked", 64'(locked), 64'h0);
        game_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (toggle_state) tog++;
        end
        game_rdy = 1'b0;
        chk("rdy_one_pulse", 64'(tog), 64'd1);
        chk("rdy_locked", 64'(locked), 64'h1);
        ng();
        chk("ng_word", 64'(setWord), 64'h0);
        chk("ng_cnt", 64'(letter_cnt), 64'd0);
        chk("ng_unlocked", 64'(locked), 64'h0);

        // Delete after confirm reopens entry
        type_word(40'h4142434445);
        enter();
        del();
        chk("armed_del_cnt", 64'(letter_cnt), 64'd4);
        chk("armed_del_word", 64'(setWord), 64'h0041424344);
        key(8'h5A);
        chk("armed_del_reedit", 64'(setWord), 64'h414243445A);
        ng();

        // Simultaneous strobes at three letters
        key(8'h41);
        key(8'h42);
        key(8'h43);
        key_del = 1'b1;
        key_valid = 1'b1;
        key_data = 8'h44;
        key_enter = 1'b1;
        step();
        key_del = 1'b0;
        key_valid = 1'b0;
        key_enter = 1'b0;
        chk("simul_cnt", 64'(letter_cnt), 64'd2);
        chk("simul_noerr", 64'(load_err), 64'h0);
        chk("simul_word", 64'(setWord), 64'h4142);

        // Asynchronous reset mid-entry
        key(8'h58);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_word", 64'(setWord), 64'h0);
        chk("arst_cnt", 64'(letter_cnt), 64'h0);
        chk("arst_locked", 64'(locked), 64'h0);
        chk("arst_toggle", 64'(toggle_state), 64'h0);
        step();
        rst = 1'b0;
        key(8'h51);
        chk("post_rst_word", 64'(setWord), 64'h51);
        step();
        run_cmp = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
